// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory arbiter and the SPI master it drives.
package spi_mem_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 16;
  localparam int unsigned DATA_W_DEFAULT = 8;

  // Serial RAM opcodes, shared with the SPI master.
  localparam logic [7:0] READ_COMMAND  = 8'h03;
  localparam logic [7:0] WRITE_COMMAND = 8'h02;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_t;

  // The opcode the SPI master will shift out for a given direction.
  function automatic logic [7:0] command_for(input logic we);
    return we ? WRITE_COMMAND : READ_COMMAND;
  endfunction

endpackage

// File: rtl/spi_mem_arbiter_if.sv
// Requester and SPI-master side signals of the arbiter.
// slave = arbiter view, master = environment (core + SPI master) view.
interface spi_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              spi_start;
  logic              spi_write;
  logic [ADDR_W-1:0] spi_address;
  logic [DATA_W-1:0] spi_wdata;
  logic              spi_done;
  logic [DATA_W-1:0] spi_rdata;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, spi_done, spi_rdata,
    output f_ack, d_ack, rdata, busy, spi_start, spi_write, spi_address, spi_wdata
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, spi_done, spi_rdata,
    input  f_ack, d_ack, rdata, busy, spi_start, spi_write, spi_address, spi_wdata
  );
endinterface

// File: rtl/spi_mem_rr_arb.sv
// Two-way round-robin grant: combinational pick plus the last_grant register.
module spi_mem_rr_arb
  import spi_mem_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  req_f,
  input  logic  req_d,
  input  logic  update,
  input  port_t upd_port,
  output logic  grant_valid_c,
  output port_t grant_c
);

  port_t last_grant;

  // Reset to the data port so fetch wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= PORT_DATA;
    end else if (update) begin
      last_grant <= upd_port;
    end
  end

  always_comb begin
    grant_valid_c = req_f | req_d;
    grant_c       = PORT_FETCH;
    if (req_f && req_d) begin
      grant_c = (last_grant == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
    end else if (req_d) begin
      grant_c = PORT_DATA;
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Shares one SPI memory master between a read-only fetch port and a read/write data port.
// Optional single-entry read cache: define SPI_MEM_ARBITER_RDCACHE_EN.
module spi_mem_arbiter
  import spi_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  spi_mem_arbiter_if.slave bus
);

  state_t            state;
  port_t             grant_q;
  logic              arb_valid_c;
  port_t             arb_grant_c;
  logic              resp_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;
  logic              cache_hit_c;
  logic [DATA_W-1:0] cache_data;
  logic              read_done_c;
  logic              write_done_c;

  assign resp_c = (state == RESP);

  spi_mem_rr_arb u_arb (
    .clk           (clk),
    .rst           (rst),
    .req_f         (bus.f_req),
    .req_d         (bus.d_req),
    .update        (resp_c),
    .upd_port      (grant_q),
    .grant_valid_c (arb_valid_c),
    .grant_c       (arb_grant_c)
  );

  // Request fields of whichever port the arbiter currently picks; fetch never writes.
  always_comb begin
    sel_we_c    = 1'b0;
    sel_addr_c  = bus.f_addr;
    sel_wdata_c = '0;
    if (arb_grant_c == PORT_DATA) begin
      sel_we_c    = bus.d_we;
      sel_addr_c  = bus.d_addr;
      sel_wdata_c = bus.d_wdata;
    end
  end

  assign read_done_c  = (state == WAIT_DONE) && bus.spi_done && !bus.spi_write;
  assign write_done_c = (state == WAIT_DONE) && bus.spi_done &&  bus.spi_write;

`ifdef SPI_MEM_ARBITER_RDCACHE_EN
  logic              cache_valid;
  logic [ADDR_W-1:0] cache_tag;

  assign cache_hit_c = !sel_we_c && cache_valid && (cache_tag == sel_addr_c);

  // Every SPI read refills the entry; a write to the cached address keeps it coherent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
    end else if (read_done_c) begin
      cache_valid <= 1'b1;
      cache_tag   <= bus.spi_address;
      cache_data  <= bus.spi_rdata;
    end else if (write_done_c && cache_valid && (cache_tag == bus.spi_address)) begin
      cache_data  <= bus.spi_wdata;
    end
  end
`else
  assign cache_hit_c = 1'b0;
  assign cache_data  = '0;
`endif

  // Transaction sequencer; spi_* request fields stay frozen from ISSUE through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      grant_q         <= PORT_FETCH;
      bus.f_ack       <= 1'b0;
      bus.d_ack       <= 1'b0;
      bus.busy        <= 1'b0;
      bus.spi_start   <= 1'b0;
      bus.spi_write   <= 1'b0;
      bus.spi_address <= '0;
      bus.spi_wdata   <= '0;
      bus.rdata       <= '0;
    end else begin
      bus.f_ack     <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.spi_start <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid_c && bus.spi_done) begin
            grant_q         <= arb_grant_c;
            bus.spi_write   <= sel_we_c;
            bus.spi_address <= sel_addr_c;
            bus.spi_wdata   <= sel_wdata_c;
            bus.busy        <= 1'b1;
            if (cache_hit_c) begin
              bus.rdata <= cache_data;
              bus.f_ack <= (arb_grant_c == PORT_FETCH);
              bus.d_ack <= (arb_grant_c == PORT_DATA);
              state     <= RESP;
            end else begin
              bus.spi_start <= 1'b1;
              state         <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!bus.spi_done) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (bus.spi_done) begin
            if (!bus.spi_write) begin
              bus.rdata <= bus.spi_rdata;
            end
            bus.f_ack <= (grant_q == PORT_FETCH);
            bus.d_ack <= (grant_q == PORT_DATA);
            state     <= RESP;
          end
        end
        RESP: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
